// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: matrix/send request in, UART line and transfer status out
interface result_uart_tx_if;
  logic [53:0] result;
  logic send;
  logic tx;
  logic busy;
  logic done;
  logic [3:0] elem_idx;
  modport master (output result, send, input tx, busy, done, elem_idx);
  modport slave (input result, send, output tx, busy, done, elem_idx);
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx: sends a packed 3x3 matrix of 6-bit elements as nine 8N1 UART bytes; ports clk, rst (async high), bus (result/send in, tx/busy/done/elem_idx out)
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic clk,
  input logic rst,
  result_uart_tx_if.slave bus
);
  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d, bit_nx;
  logic [3:0] idx_q, idx_d;
  logic [53:0] shadow_q, shadow_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] cur_byte;
  logic last;
  assign cur_byte = {2'b00, shadow_q[5:0]};
  assign last = cnt_q == CNT_MAX;
  assign bit_nx = bit_q + 3'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  // the shadow shifts down one element per byte, so the current element is always shadow_q[5:0]
  always_comb begin
    state_d = state_q;
    cnt_d = last ? 16'd0 : cnt_q + 16'd1;
    bit_d = bit_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.send) begin
          shadow_d = bus.result;
          state_d = START;
          tx_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      START: if (last) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = cur_byte[0];
      end
      DATA: if (last) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_nx;
        tx_d = bit_q == 3'd7 ? 1'b1 : cur_byte[bit_nx];
      end
      STOP: if (last) begin
        state_d = idx_q == 4'd8 ? IDLE : START;
        idx_d = idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1;
        shadow_d = shadow_q >> 6;
        tx_d = idx_q == 4'd8;
        busy_d = idx_q != 4'd8;
        done_d = idx_q == 4'd8;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.tx = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.elem_idx = idx_q;
endmodule
